// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
// Latency: grant/issue combinational in IDLE; response MEM_LAT cycles after issue, next grant one cycle later.
// Backpressure: one access outstanding; requests seen outside IDLE are not granted and must be held.
//
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   if_req/if_addr           fetch request in; if_gnt, if_rvalid, if_rdata out
//   d_req/d_we/d_addr/...    data request in; d_gnt, d_rvalid, d_rdata out
//   mem_en/we/addr/wdata/be  memory issue out; mem_rdata in (valid MEM_LAT after mem_en)
//   busy                     a transaction is outstanding
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

    logic [1:0] state;
    logic [3:0] lat_cnt;
    logic [3:0] streak;
    logic       owner;        // 0 = fetch, 1 = data
    logic       owner_store;  // outstanding data access is a store: return 0, not memory data
    logic       can_issue;
    logic       fetch_wins;
    logic       in_resp;

    // Gating with rst keeps grants (and so every mem_* output) at 0 while reset is held,
    // even though the requests themselves may still be high.
    assign can_issue  = rst && (state == S_IDLE);
    // Data normally wins; a fetch that has watched STARVE_MAX contended data grants goes first.
    assign fetch_wins = if_req && (!d_req || (streak == STREAK_MAX));
    assign if_gnt     = can_issue && fetch_wins;
    assign d_gnt      = can_issue && d_req && !fetch_wins;
    assign mem_en     = if_gnt || d_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (if_gnt) begin
            mem_be   = 4'hF;
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    assign in_resp   = (state == S_RESP);
    assign if_rvalid = in_resp && !owner;
    assign d_rvalid  = in_resp && owner;
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign d_rdata   = (d_rvalid && !owner_store) ? mem_rdata : 32'h0;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            lat_cnt     <= 4'd0;
            owner       <= 1'b0;
            owner_store <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_en) begin
                        owner       <= d_gnt;
                        owner_store <= d_gnt && d_we;
                        // lat_cnt tracks cycles elapsed since issue
                        lat_cnt     <= 4'd1;
                        state       <= (MEM_LAT >= 2) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    state   <= S_IDLE;
                    lat_cnt <= 4'd0;
                end
                default: begin
                    state   <= S_IDLE;
                    lat_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Counts data grants that overtook a waiting fetch; an uncontended data grant
    // or any fetch grant means the fetch is not being starved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= 4'd0;
        end else if (if_gnt) begin
            streak <= 4'd0;
        end else if (d_gnt) begin
            if (!if_req) begin
                streak <= 4'd0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table for single-issue muxing, hand sequences
// for timing corners, and a scoreboard that checks every response's port, data and cycle.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    // second instance at minimum latency, fetch side only
    logic        b_if_req = 1'b0;
    logic [31:0] b_if_addr = '0;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic [31:0] b_mem_rdata = '0;
    logic [3:0]  b_mem_be;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut_lat1 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
        .if_rdata(b_if_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_be(4'h0),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_be(b_mem_be), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    logic any_out;
    assign any_out = |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we,
                       mem_addr, mem_wdata, mem_be, busy};

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model for the latency-2 instance: 256 words, byte-enabled writes,
    // read data returned two cycles after issue, junk otherwise.
    logic [31:0] mem [0:255];
    logic [31:0] pipe0 = 32'hCAFE_F00D, pipe1 = 32'hCAFE_F00D, wtmp;
    assign mem_rdata = pipe1;
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wtmp = mem[mem_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) wtmp[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[mem_addr[9:2]] <= wtmp;
        end
        pipe0 <= mem_en ? mem[mem_addr[9:2]] : 32'hCAFE_F00D;
        pipe1 <= pipe0;
    end
    always @(posedge clk) b_mem_rdata <= b_mem_en ? pat(b_mem_addr) : 32'hCAFE_F00D;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard: expectations pushed on grant, popped on response.
    typedef struct {
        logic        port;   // 0 = fetch, 1 = data
        logic [31:0] data;
        int          due;
    } sb_t;
    sb_t exp_q[$];

    always @(negedge clk) begin
        if (rst) begin
            if (if_gnt) exp_q.push_back('{1'b0, mem[if_addr[9:2]], cyc + 2});
            if (d_gnt)  exp_q.push_back('{1'b1, d_we ? 32'h0 : mem[d_addr[9:2]], cyc + 2});
            chk("rvalid_exclusive", 32'(if_rvalid && d_rvalid), 32'h0);
            if (if_rvalid || d_rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(1), 32'(0));
                end else begin
                    sb_t e;
                    e = exp_q.pop_front();
                    chk("sb_port", 32'(d_rvalid), 32'(e.port));
                    chk("sb_data", d_rvalid ? d_rdata : if_rdata, e.data);
                    chk("sb_cycle", 32'(cyc), 32'(e.due));
                end
            end
            if (!if_rvalid) chk("if_rdata_idle", if_rdata, 32'h0);
            if (!d_rvalid)  chk("d_rdata_idle", d_rdata, 32'h0);
            if (!mem_en)    chk("mem_idle", mem_addr | mem_wdata | {27'h0, mem_we, mem_be}, 32'h0);
        end
    end

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        int   got [12];
        int   n;
        logic [11:0] want_f;   // 1 = fetch expected at that grant index (bit 11 first)

        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[4] = 32'h0011_0133;

        //           if_req if_addr   d_req we d_addr       d_wdata       be     ign dg we be     e_addr        e_wdata
        vecs[0] = '{1'b1, 32'h10,   1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h10,   32'h0};
        vecs[1] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h3E8,  32'h1111_1111, 4'hF, 1'b0, 1'b1, 1'b0, 4'hF, 32'h3E8,  32'h1111_1111};
        vecs[2] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h20,   32'hDEAD_BEEF, 4'h3, 1'b0, 1'b1, 1'b1, 4'h3, 32'h20,   32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 32'h40,   1'b1, 1'b0, 32'h44,   32'h0,        4'hF, 1'b0, 1'b1, 1'b0, 4'hF, 32'h44,   32'h0};
        vecs[4] = '{1'b1, 32'h13,   1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h13,   32'h0};
        vecs[5] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h1001, 32'hA5A5_5A5A, 4'hC, 1'b0, 1'b1, 1'b1, 4'hC, 32'h1001, 32'hA5A5_5A5A};
        vecs[6] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h20,   32'h0,        4'h5, 1'b0, 1'b1, 1'b0, 4'h5, 32'h20,   32'h0};
        vecs[7] = '{1'b1, 32'h80,   1'b1, 1'b1, 32'h84,   32'h0000_00FF, 4'h1, 1'b0, 1'b1, 1'b1, 4'h1, 32'h84,   32'h0000_00FF};

        // Reset state
        repeat (2) @(posedge clk);
        smp();
        chk("reset_outputs", 32'(any_out), 32'h0);
        chk("reset_outputs_lat1", 32'(|{b_if_gnt, b_if_rvalid, b_mem_en, b_busy, b_mem_addr}), 32'h0);
        step();
        rst = 1'b1;

        // Vector table: one access from IDLE, loser (if any) drops before it could be granted
        for (int i = 0; i < 8; i++) begin
            step();
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
            d_wdata = vecs[i].d_wdata; d_be = vecs[i].d_be;
            smp();
            chk($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(vecs[i].e_if_gnt));
            chk($sformatf("v%0d_d_gnt", i), 32'(d_gnt), 32'(vecs[i].e_d_gnt));
            chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_if_gnt | vecs[i].e_d_gnt));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].e_be));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            step();
            if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
            repeat (3) step();
        end

        // Lone fetch timing, request held for a second grant
        step();
        if_req = 1'b1; if_addr = 32'h10;
        smp();
        chk("t1_gnt", 32'(if_gnt), 32'h1);
        chk("t1_mem_en", 32'(mem_en), 32'h1);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_busy_T", 32'(busy), 32'h0);
        step(); smp();
        chk("t1_busy_T1", 32'(busy), 32'h1);
        chk("t1_no_gnt_T1", 32'(if_gnt), 32'h0);
        step(); smp();
        chk("t1_busy_T2", 32'(busy), 32'h1);
        chk("t1_rvalid", 32'(if_rvalid), 32'h1);
        chk("t1_rdata", if_rdata, 32'h0011_0133);
        step(); smp();
        chk("t1_regrant", 32'(if_gnt), 32'h1);
        chk("t1_busy_T3", 32'(busy), 32'h0);
        step();
        if_req = 1'b0;
        repeat (3) step();

        // Contention: data first, then the held fetch
        if_req = 1'b1; if_addr = 32'h50;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3E8; d_be = 4'hF;
        smp();
        chk("t2_d_gnt", 32'(d_gnt), 32'h1);
        chk("t2_if_no_gnt", 32'(if_gnt), 32'h0);
        step(); d_req = 1'b0; smp();
        step(); smp();
        chk("t2_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("t2_if_rvalid_T2", 32'(if_rvalid), 32'h0);
        step(); smp();
        chk("t2_if_gnt_T3", 32'(if_gnt), 32'h1);
        chk("t2_if_addr_T3", mem_addr, 32'h50);
        step(); if_req = 1'b0; smp();
        step(); smp();
        chk("t2_if_rvalid_T5", 32'(if_rvalid), 32'h1);
        chk("t2_d_rvalid_T5", 32'(d_rvalid), 32'h0);
        step(); step();

        // Store: byte enables and data through, zero read data back
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF; d_addr = 32'h20;
        smp();
        chk("t4_we", 32'(mem_we), 32'h1);
        chk("t4_be", 32'(mem_be), 32'h3);
        chk("t4_wdata", mem_wdata, 32'hDEAD_BEEF);
        step(); d_req = 1'b0; d_we = 1'b0; smp();
        step(); smp();
        chk("t4_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("t4_d_rdata", d_rdata, 32'h0);
        chk("t4_if_rvalid", 32'(if_rvalid), 32'h0);
        step(); step();

        // Starvation bound: both held for 12 grants
        for (int i = 0; i < 12; i++) got[i] = -1;
        want_f = 12'b0000_1000_0100;
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
        n = 0;
        for (int c = 0; c < 100 && n < 12; c++) begin
            smp();
            if (if_gnt) begin got[n] = 1; n = n + 1; end
            else if (d_gnt) begin got[n] = 0; n = n + 1; end
            if (n < 12) step();
        end
        step();
        if_req = 1'b0; d_req = 1'b0;
        chk("t3_grant_count", 32'(n), 32'd12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("t3_order_%0d", i), 32'(got[i]), 32'(want_f[11-i]));
        repeat (3) step();

        // Asynchronous reset in the middle of a fetch
        if_req = 1'b1; if_addr = 32'h10;
        smp();
        chk("t5_issue", 32'(if_gnt), 32'h1);
        step();
        if_req = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("t5_outputs_in_reset", 32'(any_out), 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h30;
        smp();
        chk("t5_first_idle_gnt", 32'(if_gnt), 32'h1);
        chk("t5_first_idle_addr", mem_addr, 32'h30);
        step();
        if_req = 1'b0;
        repeat (4) step();

        // Minimum latency: grant every other cycle, response in between
        b_if_req = 1'b1; b_if_addr = 32'h40;
        for (int c = 0; c < 8; c++) begin
            smp();
            chk($sformatf("t6_gnt_%0d", c), 32'(b_if_gnt), 32'(c % 2 == 0));
            chk($sformatf("t6_rvalid_%0d", c), 32'(b_if_rvalid), 32'(c % 2 == 1));
            chk($sformatf("t6_rdata_%0d", c), b_if_rdata, (c % 2 == 1) ? pat(32'h40) : 32'h0);
            step();
        end
        b_if_req = 1'b0;

        repeat (4) step();
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one unified, fixed-latency memory port between the processor's instruction-fetch path and its load/store path. It sits between the PC/fetch logic, the data-memory access logic and a single synchronous memory array. It serialises accesses, with one transaction outstanding at a time, and routes each response back to the requester that issued it. Data accesses win contention, and a bounded-starvation counter guarantees fetch progress.

## Interface
- `MEM_LAT`, 2: cycles from issue (`mem_en`=1) to valid `mem_rdata`; legal range 1..15.
- `STARVE_MAX`, 4: consecutive contended data grants after which a waiting fetch wins; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch accepted and issued this cycle.
- `if_rvalid` out 1: one-cycle fetch response strobe.
- `if_rdata` out 32: fetched word; valid only with `if_rvalid`, else 0.
- `d_req` in 1: data request; held with `d_*` stable until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_be` in 4: store byte enables.
- `d_gnt` out 1: data request accepted and issued this cycle.
- `d_rvalid` out 1: one-cycle completion strobe for loads and stores.
- `d_rdata` out 32: load data; 0 for stores and when `d_rvalid`=0.
- `mem_en` out 1: memory issue strobe.
- `mem_we` out 1: memory write.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_be` out 4: memory byte enables.
- `mem_rdata` in 32: read data, valid `MEM_LAT` cycles after `mem_en`.
- `busy` out 1: a transaction is outstanding (state ≠ IDLE).

## Operation
- **States and transitions.**
  - IDLE → WAIT: on issue when `MEM_LAT` ≥ 2.
  - IDLE → RESP: on issue when `MEM_LAT` = 1.
  - WAIT → RESP: when the latency counter reaches `MEM_LAT`−1.
  - RESP → IDLE: always.
- **Issue.** Issue happens only in IDLE.
  - The winner's `gnt`, `mem_en` and the `mem_*` fields are combinational from state and the requests, all in the same cycle.
  - The `owner` register (0 = fetch, 1 = data) is captured at issue.
- **Arbitration, when both requests are high.**
  - Data wins, unless `streak` == `STARVE_MAX`, in which case fetch wins.
  - With a single request, that requester wins.
- **`streak` counter.**
  - Increments, saturating at `STARVE_MAX`, on a data grant while `if_req`=1.
  - Clears on any fetch grant.
  - Clears on a data grant while `if_req`=0.
- **Field muxing on fetch issue:** `mem_we`=0, `mem_be`=4'hF, `mem_wdata`=0, `mem_addr`=`if_addr`.
- **Field muxing on data issue:** `mem_we`=`d_we`, `mem_be`=`d_be`, `mem_wdata`=`d_wdata`, `mem_addr`=`d_addr`.
- **Idle outputs.** All `mem_*` outputs are 0 when `mem_en`=0.
- **RESP.**
  - Exactly one of `if_rvalid`/`d_rvalid` is asserted, selected by `owner`.
  - The corresponding rdata equals `mem_rdata` in that cycle. For data stores it is 0.
  - The other port's rvalid and rdata stay 0.
- **No grants outside IDLE.** Requests arriving in WAIT or RESP are not granted; they are held by the requester and evaluated in the next IDLE cycle.
- **Unaligned addresses** pass through unchanged; the arbiter performs no alignment check.

## Timing
- **Reset values.**
  - Every output is 0.
  - State is IDLE, `streak`=0, `owner`=0, latency counter=0.
- **Asynchronous reset mid-transaction.**
  - Outputs drop to 0 immediately.
  - The outstanding response is discarded and no rvalid follows after release.
  - The first IDLE cycle after release may issue.
- **Per-transaction timing.**
  - Issue at cycle T.
  - rvalid at T+`MEM_LAT`.
  - Earliest next grant at T+`MEM_LAT`+1.
  - Throughput is one access per `MEM_LAT`+1 cycles.
- **`busy`.** Asserted from T+1 through T+`MEM_LAT`, inclusive.
- **Request dropped before grant.** If a requester drops `req` before being granted, no transaction occurs for it and it receives no rvalid.
- **Request held after grant.** Holding `req` high after `gnt` is treated as a new request in the next IDLE cycle.

## Test plan
1. **Lone fetch.** `MEM_LAT`=2; `if_req`=1, `if_addr`=0x10; memory returns 0x00110133. Required: `if_gnt`, `mem_en`=1 and `mem_addr`=0x10 at T; `busy`=1 at T+1 and T+2; `if_rvalid`=1 with `if_rdata`=0x00110133 at T+2; next `if_gnt` at T+3 with `if_req` held.
2. **Contention.** `if_req` and `d_req` rise in the same cycle (load, `d_addr`=0x3E8). Required: `d_gnt` at T; `d_rvalid` at T+2; `if_gnt` at T+3; `if_rvalid` at T+5; `d_rvalid` never coincides with `if_rvalid`.
3. **Starvation bound.** `STARVE_MAX`=4; both requests held continuously for 12 grants. Required: grant order D,D,D,D,F,D,D,D,D,F,D,D.
4. **Store.** `d_we`=1, `d_be`=4'b0011, `d_wdata`=0xDEADBEEF, `d_addr`=0x20. Required: at T `mem_we`=1, `mem_be`=0011, `mem_wdata`=0xDEADBEEF; `d_rvalid`=1 with `d_rdata`=0 at T+2; `if_rvalid` stays 0.
5. **Reset mid-transaction.** Fetch issued at T; `rst`=0 asynchronously at T+1 mid-cycle. Required: all outputs 0 within that cycle; no rvalid after release; a fetch request in the first IDLE cycle after release issues normally.
6. **Minimum latency.** `MEM_LAT`=1 with a fetch held high. Required: `if_gnt` every 2 cycles and `if_rvalid` in each intervening cycle.
